// File: rtl/sent_rx_pkg.sv
// Shared definitions for the SENT receive CRC checker.
// Includes frame codes, CRC seeds and polynomials, FSM states and the CRC step functions.
package sent_rx_pkg;

    localparam logic [2:0] CODE_NONE  = 3'b000;
    localparam logic [2:0] CODE_FAST6 = 3'b001;
    localparam logic [2:0] CODE_FAST4 = 3'b010;
    localparam logic [2:0] CODE_FAST3 = 3'b011;
    localparam logic [2:0] CODE_SHORT = 3'b100;
    localparam logic [2:0] CODE_ENH   = 3'b101;

    localparam logic [3:0] CRC4_SEED_DEF = 4'b0101;
    localparam logic [5:0] CRC6_SEED_DEF = 6'b010101;

    // x^4+x^3+x^2+1 and x^6+x^4+x^3+1
    localparam logic [4:0] CRC4_POLY = 5'b11101;
    localparam logic [6:0] CRC6_POLY = 7'b1011001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CALC,
        ST_AUG,
        ST_DONE
    } state_t;

    // nibble XOR (crc * x^4 mod p); the shift loop reproduces the T4 lookup table
    function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic [3:0] nibble);
        logic [3:0] v;
        v = crc;
        for (int i = 0; i < 4; i++)
            v = v[3] ? ({v[2:0], 1'b0} ^ CRC4_POLY[3:0]) : {v[2:0], 1'b0};
        return nibble ^ v;
    endfunction

    function automatic logic [5:0] crc6_step(input logic [5:0] crc, input logic [5:0] word);
        logic [5:0] v;
        v = crc;
        for (int i = 0; i < 6; i++)
            v = v[5] ? ({v[4:0], 1'b0} ^ CRC6_POLY[5:0]) : {v[4:0], 1'b0};
        return word ^ v;
    endfunction

endpackage

// File: rtl/sent_rx_crc_check.sv
// SENT receive CRC checker: verifies fast-frame and slow-message CRCs and publishes results.
// Optional macro SENT_RX_CRC_ERR_CNT_EN adds saturating per-channel CRC error counters.
module sent_rx_crc_check
    import sent_rx_pkg::*;
#(
    parameter logic [3:0] CRC4_SEED = CRC4_SEED_DEF,
    parameter logic [5:0] CRC6_SEED = CRC6_SEED_DEF
) (
    input  logic        clk_rx,
    input  logic        reset_rx,
    input  logic [2:0]  done_pre_data,
    input  logic [27:0] data_fast_check_crc,
    input  logic [29:0] data_channel_check_crc,
    input  logic [7:0]  id_decode,
    input  logic [15:0] data_decode,
    input  logic        config_bit_decode,
    output logic        fast_valid,
    output logic        fast_crc_ok,
    output logic [23:0] fast_data,
    output logic [2:0]  fast_nibbles,
    output logic        slow_valid,
    output logic        slow_crc_ok,
    output logic        slow_enhanced,
    output logic [7:0]  slow_id,
    output logic [15:0] slow_data,
    output logic        slow_cfg,
    output logic        overrun
`ifdef SENT_RX_CRC_ERR_CNT_EN
    ,
    output logic [7:0]  fast_err_cnt,
    output logic [7:0]  slow_err_cnt
`endif
);

    state_t      state, state_nxt;
    logic [2:0]  code_q;
    logic [2:0]  words_left;
    logic [2:0]  n_words;
    logic [23:0] word_sr;
    logic [5:0]  crc_q;
    logic [5:0]  rx_crc_q;
    logic [5:0]  crc_fin;
    logic [23:0] fast_data_q;
    logic [7:0]  slow_id_q;
    logic [15:0] slow_data_q;
    logic        slow_cfg_q;
    logic        strobe;
    logic        code_enh;
    logic        code_fast;
    logic        crc_match;

    assign strobe    = (done_pre_data != CODE_NONE) && (done_pre_data <= CODE_ENH);
    assign code_enh  = (code_q == CODE_ENH);
    assign code_fast = (code_q == CODE_FAST6) || (code_q == CODE_FAST4) || (code_q == CODE_FAST3);

    always_comb begin
        case (code_q)
            CODE_FAST6:           n_words = 3'd6;
            CODE_FAST4, CODE_ENH: n_words = 3'd4;
            default:              n_words = 3'd3;
        endcase
    end

    always_ff @(posedge clk_rx or posedge reset_rx) begin
        if (reset_rx) begin
            state      <= ST_IDLE;
            code_q     <= CODE_NONE;
            words_left <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && strobe)
                code_q <= done_pre_data;
            if (state == ST_LOAD)
                words_left <= n_words;
            else if (state == ST_CALC)
                words_left <= words_left - 3'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (strobe) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_CALC;
            ST_CALC: if (words_left == 3'd1) state_nxt = ST_AUG;
            ST_AUG:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Data ports are valid one cycle after the strobe, so everything is captured in LOAD.
    // The word shifter is left-aligned so the next word is always at the top.
    always_ff @(posedge clk_rx) begin
        if (state == ST_LOAD) begin
            crc_q <= code_enh ? CRC6_SEED : {2'b00, CRC4_SEED};
            case (code_q)
                CODE_FAST6: begin
                    word_sr     <= data_fast_check_crc[27:4];
                    fast_data_q <= data_fast_check_crc[27:4];
                end
                CODE_FAST4: begin
                    word_sr     <= {data_fast_check_crc[19:4], 8'h00};
                    fast_data_q <= {8'h00, data_fast_check_crc[19:4]};
                end
                CODE_FAST3: begin
                    word_sr     <= {data_fast_check_crc[15:4], 12'h000};
                    fast_data_q <= {12'h000, data_fast_check_crc[15:4]};
                end
                CODE_ENH:   word_sr <= data_channel_check_crc[29:6];
                default:    word_sr <= {data_channel_check_crc[15:4], 12'h000};
            endcase
            if (code_fast)
                rx_crc_q <= {2'b00, data_fast_check_crc[3:0]};
            else if (code_enh)
                rx_crc_q <= data_channel_check_crc[5:0];
            else
                rx_crc_q <= {2'b00, data_channel_check_crc[3:0]};
            slow_id_q   <= id_decode;
            slow_data_q <= code_enh ? data_decode : {8'h00, data_decode[7:0]};
            slow_cfg_q  <= code_enh & config_bit_decode;
        end else if (state == ST_CALC) begin
            if (code_enh) begin
                crc_q   <= crc6_step(crc_q, word_sr[23:18]);
                word_sr <= {word_sr[17:0], 6'h00};
            end else begin
                crc_q   <= {2'b00, crc4_step(crc_q[3:0], word_sr[23:20])};
                word_sr <= {word_sr[19:0], 4'h0};
            end
        end
    end

    // Augmentation step folded into the result registers so the strobe lands in DONE.
    assign crc_fin   = code_enh ? crc6_step(crc_q, 6'h00) : {2'b00, crc4_step(crc_q[3:0], 4'h0)};
    assign crc_match = (crc_fin == rx_crc_q);

    always_ff @(posedge clk_rx or posedge reset_rx) begin
        if (reset_rx) begin
            fast_valid    <= 1'b0;
            fast_crc_ok   <= 1'b0;
            fast_data     <= '0;
            fast_nibbles  <= '0;
            slow_valid    <= 1'b0;
            slow_crc_ok   <= 1'b0;
            slow_enhanced <= 1'b0;
            slow_id       <= '0;
            slow_data     <= '0;
            slow_cfg      <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            fast_valid <= 1'b0;
            slow_valid <= 1'b0;
            overrun    <= strobe && (state != ST_IDLE);
            if (state == ST_AUG) begin
                if (code_fast) begin
                    fast_valid   <= 1'b1;
                    fast_crc_ok  <= crc_match;
                    fast_data    <= fast_data_q;
                    fast_nibbles <= n_words;
                end else begin
                    slow_valid    <= 1'b1;
                    slow_crc_ok   <= crc_match;
                    slow_enhanced <= code_enh;
                    slow_id       <= slow_id_q;
                    slow_data     <= slow_data_q;
                    slow_cfg      <= slow_cfg_q;
                end
            end
        end
    end

`ifdef SENT_RX_CRC_ERR_CNT_EN
    always_ff @(posedge clk_rx or posedge reset_rx) begin
        if (reset_rx) begin
            fast_err_cnt <= '0;
            slow_err_cnt <= '0;
        end else if (state == ST_AUG && !crc_match) begin
            if (code_fast && fast_err_cnt != 8'hFF)
                fast_err_cnt <= fast_err_cnt + 8'd1;
            if (!code_fast && slow_err_cnt != 8'hFF)
                slow_err_cnt <= slow_err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sent_rx_crc_check.sv
// Self-checking bench for sent_rx_crc_check: directed literal cases plus randomized traffic
// scored against a polynomial-division model of the SENT CRCs.
`timescale 1ns/1ps
module tb_sent_rx_crc_check;

    logic        clk_rx = 1'b0;
    logic        reset_rx;
    logic [2:0]  done_pre_data;
    logic [27:0] data_fast_check_crc;
    logic [29:0] data_channel_check_crc;
    logic [7:0]  id_decode;
    logic [15:0] data_decode;
    logic        config_bit_decode;
    logic        fast_valid, fast_crc_ok;
    logic [23:0] fast_data;
    logic [2:0]  fast_nibbles;
    logic        slow_valid, slow_crc_ok, slow_enhanced, slow_cfg;
    logic [7:0]  slow_id;
    logic [15:0] slow_data;
    logic        overrun;
`ifdef SENT_RX_CRC_ERR_CNT_EN
    logic [7:0]  fast_err_cnt, slow_err_cnt;
`endif

    sent_rx_crc_check dut (
        .clk_rx                 (clk_rx),
        .reset_rx               (reset_rx),
        .done_pre_data          (done_pre_data),
        .data_fast_check_crc    (data_fast_check_crc),
        .data_channel_check_crc (data_channel_check_crc),
        .id_decode              (id_decode),
        .data_decode            (data_decode),
        .config_bit_decode      (config_bit_decode),
        .fast_valid             (fast_valid),
        .fast_crc_ok            (fast_crc_ok),
        .fast_data              (fast_data),
        .fast_nibbles           (fast_nibbles),
        .slow_valid             (slow_valid),
        .slow_crc_ok            (slow_crc_ok),
        .slow_enhanced          (slow_enhanced),
        .slow_id                (slow_id),
        .slow_data              (slow_data),
        .slow_cfg               (slow_cfg),
        .overrun                (overrun)
`ifdef SENT_RX_CRC_ERR_CNT_EN
        ,
        .fast_err_cnt           (fast_err_cnt),
        .slow_err_cnt           (slow_err_cnt)
`endif
    );

    always #5 clk_rx = ~clk_rx;

    int cyc = 0;
    always @(posedge clk_rx) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    typedef struct {int at; logic ok; logic [23:0] data; logic [2:0] nib;} fast_ev_t;
    typedef struct {int at; logic ok; logic enh; logic [7:0] id; logic [15:0] data; logic cfg;} slow_ev_t;
    fast_ev_t fq[$];
    slow_ev_t sq[$];
    int       oq[$];
    int       busy_until;

    logic        e_fok, e_sok, e_senh, e_scfg;
    logic [23:0] e_fdata;
    logic [2:0]  e_fnib;
    logic [7:0]  e_sid;
    logic [15:0] e_sdata;
    int          e_ferr, e_serr;

    logic        pend;
    logic [27:0] p_fw;
    logic [29:0] p_cw;
    logic [7:0]  p_id;
    logic [15:0] p_dd;
    logic        p_cfg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Remainder of message polynomial m (nbits long) divided by poly of degree deg.
    function automatic logic [7:0] polymod(input logic [63:0] m, input int nbits,
                                           input logic [7:0] poly, input int deg);
        logic [63:0] r;
        r = m;
        for (int i = nbits - 1; i >= deg; i--)
            if (r[i]) r = r ^ (64'(poly) << (i - deg));
        return 8'(r & ((64'd1 << deg) - 64'd1));
    endfunction

    // CRC = {seed, data nibbles, zero augmentation nibble} mod p
    function automatic logic [3:0] crc4_model(input logic [3:0] seed, input logic [23:0] d, input int w);
        logic [63:0] m;
        logic [7:0]  r;
        m = (64'(seed) << (4 * w + 4)) | (64'(d) << 4);
        r = polymod(m, 4 * w + 8, 8'h1D, 4);
        return r[3:0];
    endfunction

    function automatic logic [5:0] crc6_model(input logic [5:0] seed, input logic [23:0] d);
        logic [63:0] m;
        logic [7:0]  r;
        m = (64'(seed) << 30) | (64'(d) << 6);
        r = polymod(m, 36, 8'h59, 6);
        return r[5:0];
    endfunction

    function automatic int words_for(input logic [2:0] code);
        case (code)
            3'd1:    return 6;
            3'd2:    return 4;
            3'd5:    return 4;
            default: return 3;
        endcase
    endfunction

    function automatic logic [23:0] fast_payload(input logic [27:0] fw, input int w);
        return 24'((fw >> 4) % (28'd1 << (4 * w)));
    endfunction

    task automatic model_reset();
        fq.delete(); sq.delete(); oq.delete();
        busy_until = -1;
        e_fok = 0; e_fdata = 0; e_fnib = 0;
        e_sok = 0; e_senh = 0; e_sid = 0; e_sdata = 0; e_scfg = 0;
        e_ferr = 0; e_serr = 0;
        pend = 0;
    endtask

    task automatic model_strobe(input logic [2:0] code, input logic [27:0] fw, input logic [29:0] cw,
                                input logic [7:0] id, input logic [15:0] dd, input logic cfg, input int c);
        int w;
        fast_ev_t fe;
        slow_ev_t se;
        if (code == 3'd0 || code > 3'd5) return;
        if (c <= busy_until) begin
            oq.push_back(c + 1);
            return;
        end
        w = words_for(code);
        busy_until = c + w + 3;
        if (code <= 3'd3) begin
            fe.at   = c + w + 3;
            fe.data = fast_payload(fw, w);
            fe.nib  = 3'(w);
            fe.ok   = (crc4_model(4'h5, fe.data, w) == fw[3:0]);
            fq.push_back(fe);
        end else begin
            se.at  = c + w + 3;
            se.id  = id;
            se.enh = (code == 3'd5);
            if (code == 3'd4) begin
                se.ok   = (crc4_model(4'h5, 24'(cw[15:4]), 3) == cw[3:0]);
                se.data = {8'h00, dd[7:0]};
                se.cfg  = 1'b0;
            end else begin
                se.ok   = (crc6_model(6'h15, cw[29:6]) == cw[5:0]);
                se.data = dd;
                se.cfg  = cfg;
            end
            sq.push_back(se);
        end
    endtask

    // One clock of stimulus: data for the previous strobe (or junk), plus this cycle's code.
    task automatic drive(input logic [2:0] code, input logic [27:0] fw, input logic [29:0] cw,
                         input logic [7:0] id, input logic [15:0] dd, input logic cfg);
        @(posedge clk_rx);
        #1;
        if (pend) begin
            data_fast_check_crc = p_fw; data_channel_check_crc = p_cw;
            id_decode = p_id; data_decode = p_dd; config_bit_decode = p_cfg;
        end else begin
            data_fast_check_crc = 28'($urandom); data_channel_check_crc = 30'($urandom);
            id_decode = 8'($urandom); data_decode = 16'($urandom); config_bit_decode = 1'($urandom);
        end
        done_pre_data = code;
        model_strobe(code, fw, cw, id, dd, cfg, cyc);
        pend = (code >= 3'd1 && code <= 3'd5);
        p_fw = fw; p_cw = cw; p_id = id; p_dd = dd; p_cfg = cfg;
    endtask

    task automatic idle_cycle();
        drive(3'd0, '0, '0, '0, '0, 1'b0);
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) idle_cycle();
        @(negedge clk_rx);
    endtask

    task automatic make_txn(input logic [2:0] code, input bit good, output logic [27:0] fw,
                            output logic [29:0] cw, output logic [7:0] id, output logic [15:0] dd,
                            output logic cfg);
        fw = 28'($urandom); cw = 30'($urandom); id = 8'($urandom); dd = 16'($urandom); cfg = 1'($urandom);
        if (good) begin
            if (code <= 3'd3)
                fw[3:0] = crc4_model(4'h5, fast_payload(fw, words_for(code)), words_for(code));
            else if (code == 3'd4)
                cw[3:0] = crc4_model(4'h5, 24'(cw[15:4]), 3);
            else
                cw[5:0] = crc6_model(6'h15, cw[29:6]);
        end
    endtask

    always @(negedge clk_rx) begin
        if (chk_en) begin
            logic fv, sv, ov;
            fv = 0; sv = 0; ov = 0;
            if (fq.size() > 0 && fq[0].at == cyc) begin
                fv = 1; e_fok = fq[0].ok; e_fdata = fq[0].data; e_fnib = fq[0].nib;
                if (!fq[0].ok && e_ferr < 255) e_ferr++;
                void'(fq.pop_front());
            end
            if (sq.size() > 0 && sq[0].at == cyc) begin
                sv = 1; e_sok = sq[0].ok; e_senh = sq[0].enh; e_sid = sq[0].id;
                e_sdata = sq[0].data; e_scfg = sq[0].cfg;
                if (!sq[0].ok && e_serr < 255) e_serr++;
                void'(sq.pop_front());
            end
            if (oq.size() > 0 && oq[0] == cyc) begin
                ov = 1;
                void'(oq.pop_front());
            end
            chk("fast_valid", fast_valid, fv);
            chk("fast_crc_ok", fast_crc_ok, e_fok);
            chk("fast_data", fast_data, e_fdata);
            chk("fast_nibbles", fast_nibbles, e_fnib);
            chk("slow_valid", slow_valid, sv);
            chk("slow_crc_ok", slow_crc_ok, e_sok);
            chk("slow_enhanced", slow_enhanced, e_senh);
            chk("slow_id", slow_id, e_sid);
            chk("slow_data", slow_data, e_sdata);
            chk("slow_cfg", slow_cfg, e_scfg);
            chk("overrun", overrun, ov);
`ifdef SENT_RX_CRC_ERR_CNT_EN
            chk("fast_err_cnt", fast_err_cnt, 32'(e_ferr));
            chk("slow_err_cnt", slow_err_cnt, 32'(e_serr));
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          c, cnt, r;
        logic [2:0]  code;
        logic [27:0] fw;
        logic [29:0] cw;
        logic [7:0]  id;
        logic [15:0] dd;
        logic        cfg;

        reset_rx = 1'b0; done_pre_data = 3'd0;
        data_fast_check_crc = '0; data_channel_check_crc = '0;
        id_decode = '0; data_decode = '0; config_bit_decode = 1'b0;
        model_reset();
        #1 reset_rx = 1'b1;
        repeat (2) @(posedge clk_rx);
        #2 reset_rx = 1'b0;
        chk_en = 1'b1;
        @(negedge clk_rx);
        chk("reset fast_valid", fast_valid, 0);
        chk("reset fast_data", fast_data, 0);
        chk("reset slow_data", slow_data, 0);
        chk("reset overrun", overrun, 0);

        drive(3'd1, 28'h0000005, '0, '0, '0, 1'b0); c = cyc;
        wait_to(c + 8); chk("f6 latency early", fast_valid, 0);
        wait_to(c + 9);
        chk("f6 valid", fast_valid, 1); chk("f6 ok", fast_crc_ok, 1);
        chk("f6 data", fast_data, 0); chk("f6 nibbles", fast_nibbles, 6);

        drive(3'd1, 28'h0000004, '0, '0, '0, 1'b0); c = cyc;
        wait_to(c + 9); chk("f6 bad valid", fast_valid, 1); chk("f6 bad ok", fast_crc_ok, 0);

        drive(3'd3, 28'h0000009, '0, '0, '0, 1'b0); c = cyc;
        wait_to(c + 6);
        chk("f3 valid", fast_valid, 1); chk("f3 ok", fast_crc_ok, 1); chk("f3 nibbles", fast_nibbles, 3);

        drive(3'd4, '0, 30'h0009, 8'h00, 16'h0000, 1'b0); c = cyc;
        wait_to(c + 6);
        chk("short valid", slow_valid, 1); chk("short ok", slow_crc_ok, 1); chk("short enh", slow_enhanced, 0);

        drive(3'd4, '0, 30'h0008, 8'h00, 16'h0000, 1'b0); c = cyc;
        wait_to(c + 6); chk("short bad ok", slow_crc_ok, 0);

        drive(3'd5, '0, 30'h00000026, 8'h00, 16'h0000, 1'b1); c = cyc;
        wait_to(c + 7);
        chk("enh valid", slow_valid, 1); chk("enh ok", slow_crc_ok, 1);
        chk("enh flag", slow_enhanced, 1); chk("enh cfg", slow_cfg, 1);

        drive(3'd1, 28'h1234560, '0, '0, '0, 1'b0); c = cyc;
        idle_cycle();
        drive(3'd4, '0, 30'h0009, 8'h5A, 16'h1234, 1'b0);
        wait_to(c + 3); chk("overrun pulse", overrun, 1);
        cnt = 0;
        for (int k = c + 4; k <= c + 14; k++) begin
            wait_to(k);
            cnt += int'(slow_valid);
            if (k == c + 9) begin
                chk("overrun fast valid", fast_valid, 1);
                chk("overrun fast data", fast_data, 24'h123456);
            end
        end
        chk("overrun slow dropped", cnt, 0);

        drive(3'd6, 28'h0000005, 30'h9, '0, '0, 1'b0); c = cyc;
        cnt = 0;
        for (int k = c + 1; k <= c + 10; k++) begin
            wait_to(k);
            cnt += int'(fast_valid) + int'(slow_valid) + int'(overrun);
        end
        chk("code 110 ignored", cnt, 0);

        drive(3'd1, 28'h0000005, '0, '0, '0, 1'b0); c = cyc;
        wait_to(c + 4);
        #2 reset_rx = 1'b1;
        done_pre_data = 3'd0;
        model_reset();
        #1;
        chk("mid reset fast_data", fast_data, 0);
        chk("mid reset slow_enhanced", slow_enhanced, 0);
        chk("mid reset slow_cfg", slow_cfg, 0);
        @(posedge clk_rx);
        #2 reset_rx = 1'b0;
        cnt = 0;
        for (int k = c + 6; k <= c + 14; k++) begin
            wait_to(k);
            cnt += int'(fast_valid);
        end
        chk("mid reset no pulse", cnt, 0);
        drive(3'd3, 28'h0000009, '0, '0, '0, 1'b0); c = cyc;
        wait_to(c + 6); chk("after reset valid", fast_valid, 1); chk("after reset ok", fast_crc_ok, 1);

`ifdef SENT_RX_CRC_ERR_CNT_EN
        for (int n = 0; n < 300; n++) begin
            drive(3'd3, 28'h0000000, '0, '0, '0, 1'b0); c = cyc;
            wait_to(c + 6);
        end
        chk("fast_err_cnt saturated", fast_err_cnt, 255);
`endif

        for (int it = 0; it < 700; it++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                code = 3'($urandom_range(1, 5));
                make_txn(code, $urandom_range(0, 1) == 1, fw, cw, id, dd, cfg);
                drive(code, fw, cw, id, dd, cfg);
            end else if (r == 5) begin
                r = $urandom_range(0, 2);
                code = (r == 0) ? 3'd0 : ((r == 1) ? 3'd6 : 3'd7);
                drive(code, 28'($urandom), 30'($urandom), 8'($urandom), 16'($urandom), 1'b1);
            end else begin
                idle_cycle();
            end
        end
        repeat (15) idle_cycle();
        @(negedge clk_rx);
        chk("model queues drained", fq.size() + sq.size() + oq.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sent_rx_crc_check.md
Name: sent_rx_crc_check

Overview:
- Sits directly downstream of the SENT receive pulse decoder, on clk_rx.
- Takes each completed fast-channel frame word or slow-channel serial message word flagged by done_pre_data and verifies its CRC.
  - SENT CRC4 is used for fast frames and for short serial messages.
  - CRC6 is used for enhanced serial messages.
- Publishes the checked payload with a one-cycle valid pulse and an ok/error flag, for the store/FIFO and the host-side status logic.

Parameters:
- CRC4_SEED, 4'b0101, initial value of the CRC4 register.
- CRC6_SEED, 6'b010101, initial value of the CRC6 register.

Ports:
- clk_rx  in  1  receive clock
- reset_rx  in  1  asynchronous, active-high reset
- done_pre_data  in  3  one-cycle frame-complete code from the decoder:
  - 001: fast frame, 6 data nibbles
  - 010: fast frame, 4 data nibbles
  - 011: fast frame, 3 data nibbles
  - 100: short serial message
  - 101: enhanced serial message
  - others: ignored
- data_fast_check_crc  in  28  fast frame: data nibbles MSN-first ending at bit 4; CRC in [3:0]
- data_channel_check_crc  in  30  slow word
  - Short serial: [15:4] data, [3:0] CRC.
  - Enhanced: [29:6] data, [5:0] CRC.
- id_decode  in  8  slow message ID
- data_decode  in  16  slow message data
- config_bit_decode  in  1  enhanced configuration bit
- fast_valid  out  1  one-cycle result strobe, fast channel
- fast_crc_ok  out  1  received CRC equals computed CRC
- fast_data  out  24  checked data nibbles, right-aligned, upper bits zero
- fast_nibbles  out  3  number of data nibbles (6, 4 or 3)
- slow_valid  out  1  one-cycle result strobe, slow channel
- slow_crc_ok  out  1  slow CRC match
- slow_enhanced  out  1  1 = enhanced message, 0 = short
- slow_id  out  8  captured ID
- slow_data  out  16  captured data
- slow_cfg  out  1  captured config_bit_decode (0 for short messages)
- overrun  out  1  one-cycle pulse: a strobe arrived while busy and was dropped

Behaviour:
- Reset: all outputs 0; FSM returns to IDLE; any in-flight computation is discarded. Applies asynchronously at any point.
- IDLE:
  - Codes 001..101 latch the code and go to LOAD.
  - Codes 000, 110 and 111 are ignored.
- LOAD: the decoder updates its data ports one cycle after the strobe, so all data inputs are sampled here, never on the strobe cycle.
  - Load the word list.
  - Seed CRC4 with CRC4_SEED, or CRC6 with CRC6_SEED for enhanced.
  - Go to CALC.
- CALC: processes one word per cycle, W words, then goes to AUG.
  - CRC4 step: crc = nibble XOR T4[crc]. T4 is the x^4 multiply modulo x^4+x^3+x^2+1 (table 0,13,7,10,14,3,9,4,1,12,6,11,15,2,8,5).
  - Fast frames: nibbles taken MSN-first.
  - Short serial: nibbles [15:12], [11:8], [7:4].
  - Enhanced: CRC6 step: crc = word XOR T6[crc], where T6 is the x^6 multiply modulo x^6+x^4+x^3+1. Words are [29:24], [23:18], [17:12], [11:6].
- AUG: one extra step with a zero word (augmentation). Go to DONE.
- DONE:
  - Compare the result against the received CRC field.
  - Register the payload outputs.
  - Pulse fast_valid or slow_valid for exactly one cycle.
  - Return to IDLE.
- Latency: the valid pulse appears in cycle W+3, counting the strobe cycle as 0. That is 9 for 6 nibbles, 7 for 4 nibbles, 6 for 3 nibbles or short serial, and 7 for enhanced (W=4).
- Payload outputs hold their values until the next result on the same channel. Fast and slow outputs are independent.
- A strobe in any state other than IDLE is dropped and pulses overrun; the current computation continues unaffected.
- The slow_data upper 8 bits are 0 for short messages.

Optional Feature:
- SENT_RX_CRC_ERR_CNT_EN defined:
  - Adds outputs fast_err_cnt[7:0] and slow_err_cnt[7:0].
  - Each increments on a valid pulse with crc_ok=0, saturates at 255, and is cleared only by reset_rx.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package sent_rx_pkg holds:
  - done_pre_data code constants.
  - CRC seeds and polynomial constants.
  - FSM state enum.
  - Pure functions crc4_step(crc, nibble) and crc6_step(crc, word).
- No sub-module: the FSM plus word shifter fits one module.

Test Plan:
- Code 001, fast word 28'h0000005 -> fast_valid in cycle 9, fast_crc_ok=1, fast_data=0, fast_nibbles=6. Repeat with 28'h0000004 -> fast_crc_ok=0.
- Code 011, fast word 28'h0000009 -> fast_valid in cycle 6, fast_crc_ok=1, fast_nibbles=3.
- Code 100, channel word 30'h0009, id_decode=8'h00 -> slow_valid in cycle 6, slow_crc_ok=1, slow_enhanced=0. Repeat with 30'h0008 -> slow_crc_ok=0.
- Code 101, channel word 30'h26, config_bit_decode=1 -> slow_valid in cycle 7, slow_crc_ok=1, slow_enhanced=1, slow_cfg=1.
- Code 001 followed by code 100 two cycles later -> overrun pulse, only the fast result is produced; code 110 -> no response.
- reset_rx asserted in the middle of CALC -> no valid pulse; all outputs 0; the next strobe completes normally. With SENT_RX_CRC_ERR_CNT_EN: 300 bad fast frames -> fast_err_cnt=255.
